// File: rtl/vcm_i2c_write_sequencer_pkg.sv
// Shared types and defaults for the VCM I2C write sequencer.
// Optional NACK retry is enabled by the VCM_I2C_RETRY_EN macro.
package vcm_i2c_pkg;

  localparam int CtrW = 20;

  localparam logic [7:0] SLAVE_ADDR_DEF = 8'h18;
  localparam logic [CtrW-1:0] TIMEOUT_DEF = 20'd400000;

  typedef enum logic [2:0] {
    IDLE,
    GO_HI,
    WAIT_START,
    WAIT_DONE,
    RECOVER,
    DONE
  } state_e;

  typedef enum logic {
    OWN0 = 1'b0,
    OWN1 = 1'b1
  } owner_e;

endpackage

// File: rtl/vcm_i2c_write_sequencer_if.sv
// Requester and engine signals of the VCM I2C write sequencer.
// slave: sequencer view, master: requesters plus engine view.
interface vcm_i2c_write_sequencer_if;

  logic       REQ0;
  logic [7:0] PTR0;
  logic       REQ1;
  logic [7:0] PTR1;
  logic       GNT0;
  logic       GNT1;
  logic       DONE0;
  logic       DONE1;
  logic       ST_ACK;
  logic       ST_TO;
  logic       BUSY;
  logic       ENG_GO;
  logic [7:0] ENG_POINTER;
  logic [7:0] ENG_SLAVE_ADDRESS;
  logic       ENG_END_OK;
  logic       ENG_ACK_OK;
  logic       ENG_RESET_N;

  modport slave (
    input  REQ0, PTR0, REQ1, PTR1,
    input  ENG_END_OK, ENG_ACK_OK,
    output GNT0, GNT1, DONE0, DONE1,
    output ST_ACK, ST_TO, BUSY,
    output ENG_GO, ENG_POINTER,
    output ENG_SLAVE_ADDRESS, ENG_RESET_N
  );

  modport master (
    output REQ0, PTR0, REQ1, PTR1,
    output ENG_END_OK, ENG_ACK_OK,
    input  GNT0, GNT1, DONE0, DONE1,
    input  ST_ACK, ST_TO, BUSY,
    input  ENG_GO, ENG_POINTER,
    input  ENG_SLAVE_ADDRESS, ENG_RESET_N
  );

endinterface

// File: rtl/vcm_i2c_timeout_ctr.sv
// Saturating cycle counter with clear, enable and expiry flag.
// expired_o is high on the last cycle of a limit_i-cycle window.
module vcm_i2c_timeout_ctr #(
  parameter int W = 20
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  // count up while enabled, stick at all-ones, clear wins
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expired_o = (cnt_q == (limit_i - W'(1)));

endmodule

// File: rtl/vcm_i2c_write_sequencer.sv
// Arbitrates two requesters onto one VCM I2C write engine.
// VCM_I2C_RETRY_EN adds automatic re-arm on pointer NACK.
module vcm_i2c_write_sequencer
  import vcm_i2c_pkg::*;
#(
  parameter logic [7:0]      SLAVE_ADDR = SLAVE_ADDR_DEF,
  parameter int              GO_HOLD    = 4,
  parameter logic [CtrW-1:0] TIMEOUT    = TIMEOUT_DEF,
  parameter int              RST_HOLD   = 4,
  parameter int              RETRY_MAX  = 2
) (
  input logic PT_CK,
  input logic RESET_N,
  vcm_i2c_write_sequencer_if.slave bus
);

  localparam logic [CtrW-1:0] GoLim  = CtrW'(GO_HOLD);
  localparam logic [CtrW-1:0] RstLim = CtrW'(RST_HOLD);

  if ((GO_HOLD < 2) || (RST_HOLD < 1) ||
      (RETRY_MAX < 0) || (RETRY_MAX > 15)) begin : g_bad_cfg
    $error("vcm_i2c_write_sequencer: bad parameters");
  end

  state_e     state_q;
  owner_e     owner_q;
  logic [7:0] ptr_q;
  logic       go_q;
  logic       eng_rst_n_q;
  logic       busy_q;
  logic       gnt0_q;
  logic       gnt1_q;
  logic       done0_q;
  logic       done1_q;
  logic       ack_q;
  logic       to_q;

  logic            ctr_clr;
  logic            ctr_en;
  logic [CtrW-1:0] ctr_lim;
  logic            ctr_exp;
  logic            retry_go;

  // one shared counter: hold window, timeout budget, reset hold
  always_comb begin
    ctr_clr = 1'b1;
    ctr_en  = 1'b0;
    ctr_lim = TIMEOUT;
    unique case (state_q)
      GO_HI: begin
        ctr_lim = GoLim;
        ctr_en  = 1'b1;
        ctr_clr = ctr_exp;
      end
      WAIT_START: begin
        ctr_en  = 1'b1;
        ctr_clr = ctr_exp;
      end
      WAIT_DONE: begin
        ctr_en  = 1'b1;
        ctr_clr = ctr_exp | bus.ENG_END_OK;
      end
      RECOVER: begin
        ctr_lim = RstLim;
        ctr_en  = 1'b1;
        ctr_clr = ctr_exp;
      end
      default: ctr_clr = 1'b1;
    endcase
  end

  vcm_i2c_timeout_ctr #(
    .W(CtrW)
  ) u_ctr (
    .clk_i     (PT_CK),
    .rst_ni    (RESET_N),
    .clr_i     (ctr_clr),
    .en_i      (ctr_en),
    .limit_i   (ctr_lim),
    .expired_o (ctr_exp)
  );

`ifdef VCM_I2C_RETRY_EN
  logic [3:0] retry_q;

  assign retry_go = !bus.ENG_ACK_OK &&
                    (retry_q < 4'(RETRY_MAX));

  // attempt count, reset while idle so each grant starts fresh
  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      retry_q <= '0;
    end else if (state_q == IDLE) begin
      retry_q <= '0;
    end else if ((state_q == WAIT_DONE) && !ctr_exp &&
                 bus.ENG_END_OK && retry_go) begin
      retry_q <= retry_q + 4'd1;
    end
  end
`else
  assign retry_go = 1'b0;
`endif

  // main sequencer with registered outputs
  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      owner_q     <= OWN0;
      ptr_q       <= '0;
      go_q        <= 1'b0;
      eng_rst_n_q <= 1'b1;
      busy_q      <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      ack_q       <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.REQ0) begin
            gnt0_q  <= 1'b1;
            ptr_q   <= bus.PTR0;
            owner_q <= OWN0;
            go_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= GO_HI;
          end else if (bus.REQ1) begin
            gnt1_q  <= 1'b1;
            ptr_q   <= bus.PTR1;
            owner_q <= OWN1;
            go_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= GO_HI;
          end
        end
        GO_HI: begin
          if (ctr_exp) begin
            go_q    <= 1'b0;
            state_q <= WAIT_START;
          end
        end
        WAIT_START: begin
          if (ctr_exp) begin
            eng_rst_n_q <= 1'b0;
            go_q        <= 1'b0;
            state_q     <= RECOVER;
          end else if (!bus.ENG_END_OK) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (ctr_exp) begin
            eng_rst_n_q <= 1'b0;
            go_q        <= 1'b0;
            state_q     <= RECOVER;
          end else if (bus.ENG_END_OK) begin
            if (retry_go) begin
              go_q    <= 1'b1;
              state_q <= GO_HI;
            end else begin
              ack_q   <= bus.ENG_ACK_OK;
              to_q    <= 1'b0;
              done0_q <= (owner_q == OWN0);
              done1_q <= (owner_q == OWN1);
              state_q <= DONE;
            end
          end
        end
        RECOVER: begin
          if (ctr_exp) begin
            eng_rst_n_q <= 1'b1;
            ack_q       <= 1'b0;
            to_q        <= 1'b1;
            done0_q     <= (owner_q == OWN0);
            done1_q     <= (owner_q == OWN1);
            state_q     <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          ack_q   <= 1'b0;
          to_q    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.GNT0              = gnt0_q;
  assign bus.GNT1              = gnt1_q;
  assign bus.DONE0             = done0_q;
  assign bus.DONE1             = done1_q;
  assign bus.ST_ACK            = ack_q;
  assign bus.ST_TO             = to_q;
  assign bus.BUSY              = busy_q;
  assign bus.ENG_GO            = go_q;
  assign bus.ENG_POINTER       = ptr_q;
  assign bus.ENG_SLAVE_ADDRESS = SLAVE_ADDR;
  assign bus.ENG_RESET_N       = eng_rst_n_q;

endmodule

// File: tb/tb_vcm_i2c_write_sequencer.sv
// Bench for vcm_i2c_write_sequencer with a behavioural engine.
// Build with VCM_I2C_RETRY_EN to check the retry variant.
module tb_vcm_i2c_write_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] ptr0 = 8'h00;
  logic [7:0] ptr1 = 8'h00;
  logic       eng_end_ok = 1'b1;
  logic       eng_ack_ok = 1'b0;
  logic       eng_ack = 1'b1;
  logic       eng_hang = 1'b0;

  vcm_i2c_write_sequencer_if bus();

  assign bus.REQ0       = req0;
  assign bus.REQ1       = req1;
  assign bus.PTR0       = ptr0;
  assign bus.PTR1       = ptr1;
  assign bus.ENG_END_OK = eng_end_ok;
  assign bus.ENG_ACK_OK = eng_ack_ok;

  vcm_i2c_write_sequencer #(
    .TIMEOUT(20'd100)
  ) dut (
    .PT_CK   (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

`ifdef VCM_I2C_RETRY_EN
  localparam int NackGo = 3;
`else
  localparam int NackGo = 1;
`endif
  localparam int XferLen = 50;

  // engine: launch on GO fall, END_OK low for XferLen cycles
  logic go_e = 1'b0;
  logic eng_act = 1'b0;
  int   eng_cnt = 0;
  always @(posedge clk) begin
    go_e <= bus.ENG_GO;
    if (!bus.ENG_RESET_N) begin
      eng_end_ok <= 1'b1;
      eng_act    <= 1'b0;
    end else if (eng_act) begin
      if (eng_cnt == XferLen - 1) begin
        eng_end_ok <= 1'b1;
        eng_ack_ok <= eng_ack;
        eng_act    <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt + 1;
      end
    end else if (go_e && !bus.ENG_GO && !eng_hang) begin
      eng_act    <= 1'b1;
      eng_cnt    <= 0;
      eng_end_ok <= 1'b0;
    end
  end

  // monitor: pulse widths, event counts, busy overlap
  int   go_pulses = 0;
  int   go_bad = 0;
  int   go_run = 0;
  int   since = 0;
  int   rst_age = -1;
  int   rn_run = 0;
  int   rn_len = -1;
  int   ovl = 0;
  int   d0 = 0;
  int   d1 = 0;
  logic go_prev = 1'b0;
  logic rn_prev = 1'b1;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.ENG_GO) go_run = go_run + 1;
    if (go_prev && !bus.ENG_GO) begin
      go_pulses = go_pulses + 1;
      if (go_run != 4) go_bad = go_bad + 1;
      go_run = 0;
      since = 0;
    end else if (since < 100000) begin
      since = since + 1;
    end
    if (rn_prev && !bus.ENG_RESET_N) rst_age = since;
    if (!bus.ENG_RESET_N) rn_run = rn_run + 1;
    if (!rn_prev && bus.ENG_RESET_N) begin
      rn_len = rn_run;
      rn_run = 0;
    end
    if ((bus.GNT0 || bus.GNT1) && busy_prev) ovl = ovl + 1;
    if (bus.DONE0) d0 = d0 + 1;
    if (bus.DONE1) d1 = d1 + 1;
    go_prev   = bus.ENG_GO;
    rn_prev   = bus.ENG_RESET_N;
    busy_prev = bus.BUSY;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       r0;
    logic       r1;
    logic [7:0] p0;
    logic [7:0] p1;
    logic       ack;
    logic       hang;
    logic       e_g0;
    logic       e_g1;
    logic [7:0] e_ptr;
    int         e_go;
    logic       e_d0;
    logic       e_d1;
    logic       e_ack;
    logic       e_to;
  } vec_t;

  vec_t vecs[5];

  task automatic wait_done(output logic got);
    got = 1'b0;
    for (int t = 0; t < 3000 && !got; t++) begin
      @(negedge clk);
      if (bus.DONE0 || bus.DONE1) got = 1'b1;
    end
  endtask

  task automatic run_one(input vec_t v);
    int   gp;
    int   s0;
    int   s1;
    logic got;
    gp = go_pulses;
    s0 = d0;
    s1 = d1;
    eng_ack  = v.ack;
    eng_hang = v.hang;
    @(negedge clk);
    req0 = v.r0;
    req1 = v.r1;
    ptr0 = v.p0;
    ptr1 = v.p1;
    @(negedge clk);
    chk("gnt0", bus.GNT0, v.e_g0);
    chk("gnt1", bus.GNT1, v.e_g1);
    chk("busy_grant", bus.BUSY, 1'b1);
    chk("go_grant", bus.ENG_GO, 1'b1);
    chk("ptr_grant", bus.ENG_POINTER, v.e_ptr);
    req0 = 1'b0;
    req1 = 1'b0;
    ptr0 = ~v.p0;
    ptr1 = ~v.p1;
    wait_done(got);
    chk("done_seen", got, 1'b1);
    chk("done0", bus.DONE0, v.e_d0);
    chk("done1", bus.DONE1, v.e_d1);
    chk("st_ack", bus.ST_ACK, v.e_ack);
    chk("st_to", bus.ST_TO, v.e_to);
    chk("busy_done", bus.BUSY, 1'b1);
    chk("ptr_done", bus.ENG_POINTER, v.e_ptr);
    @(negedge clk);
    chk("busy_after", bus.BUSY, 1'b0);
    chk("done_cleared", bus.DONE0 | bus.DONE1, 1'b0);
    chk("go_count", go_pulses - gp, v.e_go);
    chk("d0_count", d0 - s0, {31'd0, v.e_d0});
    chk("d1_count", d1 - s1, {31'd0, v.e_d1});
    if (v.hang) begin
      chk("rst_age", rst_age, 100);
      chk("rst_len", rn_len, 4);
    end
  endtask

  task automatic seq_both();
    logic got;
    logic early;
    eng_ack  = 1'b1;
    eng_hang = 1'b0;
    @(negedge clk);
    req0 = 1'b1;
    req1 = 1'b1;
    ptr0 = 8'h11;
    ptr1 = 8'h22;
    @(negedge clk);
    chk("both_gnt0", bus.GNT0, 1'b1);
    chk("both_gnt1", bus.GNT1, 1'b0);
    chk("both_ptr0", bus.ENG_POINTER, 8'h11);
    req0  = 1'b0;
    got   = 1'b0;
    early = 1'b0;
    for (int t = 0; t < 3000 && !got; t++) begin
      @(negedge clk);
      if (bus.GNT1) early = 1'b1;
      if (bus.DONE0) got = 1'b1;
    end
    chk("both_done0", got, 1'b1);
    chk("both_early_gnt1", early, 1'b0);
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (bus.GNT1) got = 1'b1;
    end
    chk("both_gnt1_late", got, 1'b1);
    chk("both_ptr1", bus.ENG_POINTER, 8'h22);
    req1 = 1'b0;
    wait_done(got);
    chk("both_done1", got & bus.DONE1, 1'b1);
    chk("both_ack1", bus.ST_ACK, 1'b1);
    @(negedge clk);
    chk("both_idle", bus.BUSY, 1'b0);
  endtask

  task automatic seq_reset();
    logic got;
    int   s0;
    eng_ack  = 1'b1;
    eng_hang = 1'b0;
    @(negedge clk);
    req0 = 1'b1;
    ptr0 = 8'h5A;
    @(negedge clk);
    chk("rst_gnt0", bus.GNT0, 1'b1);
    req0 = 1'b0;
    got  = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (!eng_end_ok) got = 1'b1;
    end
    chk("rst_xfer_started", got, 1'b1);
    repeat (5) @(negedge clk);
    chk("rst_pre_ptr", bus.ENG_POINTER, 8'h5A);
    s0 = d0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", bus.BUSY, 1'b0);
    chk("rst_go", bus.ENG_GO, 1'b0);
    chk("rst_ptr", bus.ENG_POINTER, 8'h00);
    chk("rst_engrst", bus.ENG_RESET_N, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (eng_end_ok) got = 1'b1;
    end
    chk("rst_eng_end", got, 1'b1);
    repeat (5) @(negedge clk);
    chk("rst_no_done", d0 - s0, 0);
    chk("rst_idle", bus.BUSY, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 8'h77, 8'h3C, 1'b1, 1'b0,
                1'b0, 1'b1, 8'h3C, 1,
                1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'hA5, 8'h5A, 1'b1, 1'b0,
                1'b1, 1'b0, 8'hA5, 1,
                1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b0,
                1'b0, 1'b1, 8'hFF, NackGo,
                1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 8'h99, 1'b1, 1'b1,
                1'b1, 1'b0, 8'h00, 1,
                1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 8'hC3, 8'h00, 1'b0, 1'b0,
                1'b1, 1'b0, 8'hC3, NackGo,
                1'b1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("r_gnt", {bus.GNT0, bus.GNT1}, 2'b00);
    chk("r_done", {bus.DONE0, bus.DONE1}, 2'b00);
    chk("r_st", {bus.ST_ACK, bus.ST_TO}, 2'b00);
    chk("r_busy", bus.BUSY, 1'b0);
    chk("r_go", bus.ENG_GO, 1'b0);
    chk("r_ptr", bus.ENG_POINTER, 8'h00);
    chk("r_engrst", bus.ENG_RESET_N, 1'b1);
    chk("r_saddr", bus.ENG_SLAVE_ADDRESS, 8'h18);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_one(vecs[i]);
    seq_both();
    seq_reset();
    run_one(vecs[1]);

    chk("go_width", go_bad, 0);
    chk("busy_overlap", ovl, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vcm_i2c_write_sequencer.md
Name: vcm_i2c_write_sequencer

Overview:
Controller for the VCM pointer-write I2C engine. Shares the engine between two requesters: REQ0 for init/config and REQ1 for focus stepping. Drives the engine's GO/END_OK handshake, captures ACK status, and recovers a hung engine by timeout and engine reset. Sits between the focus/config logic and the single I2C write engine on the VCM bus.

Parameters:
SLAVE_ADDR, 8'h18, fixed 8-bit slave address driven to the engine (R/W bit appended by the engine)
GO_HOLD, 4, cycles ENG_GO is held high before release (>=2)
TIMEOUT, 20'd400000, PT_CK cycles allowed for the start phase plus the done phase combined
RST_HOLD, 4, cycles ENG_RESET_N is held low after a timeout
RETRY_MAX, 2, extra attempts on NACK (used only with the optional feature)

Ports:
PT_CK  in  1  clock, the same clock as the engine
RESET_N  in  1  asynchronous active-low reset
REQ0  in  1  level request from the config requester; held until GNT0
PTR0  in  8  pointer byte for REQ0, sampled at grant
REQ1  in  1  level request from the focus requester; held until GNT1
PTR1  in  8  pointer byte for REQ1, sampled at grant
GNT0  out  1  one-cycle accept pulse for REQ0
GNT1  out  1  one-cycle accept pulse for REQ1
DONE0  out  1  one-cycle completion pulse for REQ0
DONE1  out  1  one-cycle completion pulse for REQ1
ST_ACK  out  1  valid with DONEx: 1 = pointer byte ACKed
ST_TO  out  1  valid with DONEx: 1 = timeout
BUSY  out  1  high from grant until the DONE cycle, inclusive
ENG_GO  out  1  to engine GO
ENG_POINTER  out  8  to engine POINTER; held stable for the whole transfer
ENG_SLAVE_ADDRESS  out  8  to engine SLAVE_ADDRESS, constant SLAVE_ADDR
ENG_END_OK  in  1  from engine END_OK
ENG_ACK_OK  in  1  from engine ACK_OK
ENG_RESET_N  out  1  to engine RESET_N

Behaviour:
- Reset values: ENG_GO=0, ENG_POINTER=0, ENG_RESET_N=1, all GNT/DONE/ST_*=0, BUSY=0, state=IDLE, counters=0.
- Engine protocol: a transfer is armed by GO high and launched by GO falling. The engine drops END_OK when the transfer starts and raises it when the transfer ends.
- IDLE: if REQ0, pulse GNT0, latch PTR0 and owner=0. Else if REQ1, pulse GNT1, latch PTR1 and owner=1. REQ0 has fixed priority; simultaneous requests grant REQ0. On grant: ENG_GO<=1, BUSY<=1, go to GO_HI.
- GO_HI: count GO_HOLD cycles, then ENG_GO<=0 and go to WAIT_START. Clear the timeout counter on entry to GO_HI.
- WAIT_START: on ENG_END_OK==0, go to WAIT_DONE.
- WAIT_DONE: on ENG_END_OK==1, sample ENG_ACK_OK into ST_ACK, set ST_TO=0, go to DONE.
- Timeout: the counter increments in WAIT_START and WAIT_DONE. At TIMEOUT (counter==TIMEOUT-1 on that cycle): ENG_RESET_N<=0, ENG_GO<=0, go to RECOVER.
- RECOVER: hold ENG_RESET_N low for RST_HOLD cycles, release it, then go to DONE with ST_TO=1, ST_ACK=0.
- DONE: one-cycle DONEx pulse to the owner, with ST_ACK/ST_TO valid in that same cycle. BUSY is high in this cycle; it goes low and the FSM returns to IDLE next cycle.
- Latency to first ENG_GO: 1 cycle after REQ is seen.
- Minimum grant-to-grant spacing: GO_HOLD + 3 + engine transfer time.
- REQx dropping after grant has no effect on the transfer in flight.
- A new REQ during BUSY waits; it is not queued beyond the level.
- Counters saturate and never wrap.
- RESET_N asserted mid-transfer: return to IDLE immediately with reset values. No DONE is issued for the aborted transfer.

Optional Feature:
VCM_I2C_RETRY_EN.
- Defined: if the sampled ENG_ACK_OK==0 and the attempt count < RETRY_MAX, increment the count, go to GO_HI (re-arm with the same pointer), and issue no DONE. DONE/ST_ACK=0 is issued after RETRY_MAX+1 failed attempts. The count is cleared at grant. A timeout never retries.
- Undefined: a NACK completes at once with ST_ACK=0, and the retry counter logic is absent.

Decomposition:
- Package vcm_i2c_pkg holds:
  - state enum: IDLE, GO_HI, WAIT_START, WAIT_DONE, RECOVER, DONE
  - owner encoding
  - default SLAVE_ADDR and TIMEOUT constants
- One sub-module, vcm_i2c_timeout_ctr: a saturating counter with clear/enable/expired outputs, reused for the GO_HOLD, TIMEOUT and RST_HOLD counts.

Test Plan:
- REQ1 alone with PTR1=8'h3C; engine model ACKs and holds END_OK low for 50 cycles. Required: GNT1 1 cycle after REQ1; ENG_POINTER=8'h3C; ENG_GO high exactly 4 cycles; DONE1 with ST_ACK=1, ST_TO=0.
- REQ0 and REQ1 asserted in the same cycle. Required: GNT0 first; GNT1 only after DONE0; no overlap of BUSY periods.
- Engine model never drops END_OK, with TIMEOUT set to 100. Required: ENG_RESET_N low 4 cycles starting at cycle 100 after GO release; DONE with ST_TO=1, ST_ACK=0.
- Engine NACKs (ACK_OK=0), with VCM_I2C_RETRY_EN defined and RETRY_MAX=2. Required: 3 GO pulses, then one DONE with ST_ACK=0. Without the macro: 1 GO pulse, then DONE with ST_ACK=0.
- RESET_N pulsed low in WAIT_DONE. Required: outputs at reset values in the same cycle; no DONE; the next REQ0 is granted normally.
